microwave_ctrl: RTL

Cooking-cycle controller for the microwave. Sits directly downstream of the MM:SS countdown timer: it consumes the timer's zero flag and drives the timer's count enable, load and clear. It also turns debounced keypad digits into timer load strobes, generates the 1 Hz countdown tick and switches the magnetron.

---
 rtl/microwave_pkg.sv | 19 +
 rtl/microwave_ctrl_if.sv | 29 ++
 rtl/tick_prescaler.sv | 42 ++++
 rtl/microwave_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cooking-cycle controller.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int TICK_DIV_DEFAULT  = 50_000_000;
  localparam int BEEP_SECS_DEFAULT = 3;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/microwave_ctrl_if.sv
// Keypad, button, door and timer signals of the microwave controller.
// The beep wire exists only when MICROWAVE_BEEP_EN is defined.
interface microwave_ctrl_if;
  logic [3:0] key_digit;
  logic       key_valid;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_clearn;
  logic       timer_en;
  logic       mag_on;
  logic       done;
`ifdef MICROWAVE_BEEP_EN
  logic       beep;

  modport master (output key_digit, key_valid, start, stop, door_closed, timer_zero,
                  input  timer_data, timer_loadn, timer_clearn, timer_en, mag_on, done, beep);
  modport slave  (input  key_digit, key_valid, start, stop, door_closed, timer_zero,
                  output timer_data, timer_loadn, timer_clearn, timer_en, mag_on, done, beep);
`else
  modport master (output key_digit, key_valid, start, stop, door_closed, timer_zero,
                  input  timer_data, timer_loadn, timer_clearn, timer_en, mag_on, done);
  modport slave  (input  key_digit, key_valid, start, stop, door_closed, timer_zero,
                  output timer_data, timer_loadn, timer_clearn, timer_en, mag_on, done);
`endif
endinterface

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every TICK_DIV running cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic clearn,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_q, count_d;

  assign tick = run & (count_q == LAST);

  // Next count: restart wins, wrap on tick, hold while not running.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = {W{1'b0}};
    end else if (tick) begin
      count_d = {W{1'b0}};
    end else if (run) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Cooking-cycle controller: keypad loads, 1 Hz countdown enable, magnetron drive.
// Define MICROWAVE_BEEP_EN to add the buzzer and the self-timed DONE exit.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int BEEP_SECS = BEEP_SECS_DEFAULT
) (
  input logic             clock,
  input logic             clearn,
  microwave_ctrl_if.slave bus
);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end
  if (BEEP_SECS < 1) begin : g_bad_beep_secs
    $error("BEEP_SECS must be at least 1");
  end

  state_e     state_q, state_d;
  logic       start_prev_q, stop_prev_q;
  logic [3:0] timer_data_q, timer_data_d;
  logic       timer_loadn_q, timer_loadn_d;
  logic       timer_clearn_q, timer_clearn_d;
  logic       timer_en_q, timer_en_d;
  logic       mag_on_q, mag_on_d;
  logic       done_q, done_d;

  logic start_edge_s, stop_edge_s, door_open_s, key_ok_s, start_go_s;
  logic cook_stay_s, cook_done_s, run_s, restart_s, tick_s;

  assign start_edge_s = bus.start & ~start_prev_q;
  assign stop_edge_s  = bus.stop & ~stop_prev_q;
  assign door_open_s  = ~bus.door_closed;
  assign key_ok_s     = bus.key_valid & is_bcd(bus.key_digit);
  assign start_go_s   = start_edge_s & bus.door_closed & ~bus.timer_zero;

  // The prescaler only advances on cycles that stay in COOKING, so a pause holds it exactly.
  assign cook_stay_s = (state_q == COOKING) & ~stop_edge_s & ~door_open_s & ~bus.timer_zero;
  assign cook_done_s = (state_q == COOKING) & ~stop_edge_s & ~door_open_s & bus.timer_zero;
  assign restart_s   = ((state_q == IDLE) & ~stop_edge_s & start_go_s) | cook_done_s;

`ifdef MICROWAVE_BEEP_EN
  localparam int SECS_W = $clog2(BEEP_SECS + 1);
  localparam logic [SECS_W-1:0] SECS_LAST = SECS_W'(BEEP_SECS - 1);
  logic [SECS_W-1:0] secs_q, secs_d;
  logic              beep_q, beep_d;
  assign run_s    = cook_stay_s | (state_q == DONE);
  assign bus.beep = beep_q;
`else
  assign run_s = cook_stay_s;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock   (clock),
    .clearn  (clearn),
    .run     (run_s),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d        = state_q;
    timer_data_d   = timer_data_q;
    timer_loadn_d  = 1'b1;
    timer_clearn_d = 1'b1;
`ifdef MICROWAVE_BEEP_EN
    secs_d         = secs_q;
`endif
    case (state_q)
      IDLE: begin
        if (stop_edge_s) begin
          timer_clearn_d = 1'b0;
        end else if (start_go_s) begin
          state_d = COOKING;
        end else if (key_ok_s) begin
          timer_data_d  = bus.key_digit;
          timer_loadn_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      COOKING: begin
        if (stop_edge_s || door_open_s) begin
          state_d = PAUSED;
        end else if (bus.timer_zero) begin
          state_d = DONE;
`ifdef MICROWAVE_BEEP_EN
          secs_d  = {SECS_W{1'b0}};
`endif
        end else begin
          state_d = COOKING;
        end
      end
      PAUSED: begin
        if (stop_edge_s) begin
          state_d        = IDLE;
          timer_clearn_d = 1'b0;
        end else if (start_edge_s && bus.door_closed) begin
          state_d = COOKING;
        end else begin
          state_d = PAUSED;
        end
      end
      DONE: begin
        if (stop_edge_s || door_open_s) begin
          state_d = IDLE;
`ifdef MICROWAVE_BEEP_EN
        end else if (tick_s) begin
          if (secs_q == SECS_LAST) begin
            state_d = IDLE;
          end else begin
            secs_d = secs_q + 1'b1;
          end
`endif
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    timer_en_d = tick_s & cook_stay_s;
    mag_on_d   = (state_d == COOKING);
    done_d     = (state_d == DONE);
`ifdef MICROWAVE_BEEP_EN
    beep_d     = (state_d == DONE);
`endif
  end

  // State, edge-detector and output registers.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_q        <= IDLE;
      start_prev_q   <= 1'b1;
      stop_prev_q    <= 1'b1;
      timer_data_q   <= 4'd0;
      timer_loadn_q  <= 1'b1;
      timer_clearn_q <= 1'b0;
      timer_en_q     <= 1'b0;
      mag_on_q       <= 1'b0;
      done_q         <= 1'b0;
`ifdef MICROWAVE_BEEP_EN
      secs_q         <= {SECS_W{1'b0}};
      beep_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      start_prev_q   <= bus.start;
      stop_prev_q    <= bus.stop;
      timer_data_q   <= timer_data_d;
      timer_loadn_q  <= timer_loadn_d;
      timer_clearn_q <= timer_clearn_d;
      timer_en_q     <= timer_en_d;
      mag_on_q       <= mag_on_d;
      done_q         <= done_d;
`ifdef MICROWAVE_BEEP_EN
      secs_q         <= secs_d;
      beep_q         <= beep_d;
`endif
    end
  end

  assign bus.timer_data   = timer_data_q;
  assign bus.timer_loadn  = timer_loadn_q;
  assign bus.timer_clearn = timer_clearn_q;
  assign bus.timer_en     = timer_en_q;
  assign bus.mag_on       = mag_on_q;
  assign bus.done         = done_q;

endmodule
